// File: rtl/laplace_pkg.sv
// laplace_pkg
// Shared types and helpers for the Laplace window generator slice.
//   PIX_W      : pixel width in bits (8, matching the downstream adder stage)
//   pixel_t    : one pixel
//   window_t   : centre pixel plus its four orthogonal neighbours
//   cnt_width  : bit width of a counter/address that spans 0..n-1
package laplace_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t c;
    pixel_t n;
    pixel_t s;
    pixel_t e;
    pixel_t w;
  } window_t;

  // Always at least one bit, so a degenerate size still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/laplace_line_buf.sv
// laplace_line_buf
// One image row of pixel storage, DEPTH x PIX_W.
// Read is combinational from the same address that is written on the clock
// edge, so a read in the same cycle as a write returns the old contents.
// Storage is deliberately not reset; the window generator only trusts a
// row once it has been written in the current frame.
// Ports:
//   clk      in   clock, write on rising edge
//   wr_en    in   write enable
//   addr     in   shared read/write address (column)
//   wr_data  in   pixel to store
//   rd_data  out  pixel currently stored at addr
module laplace_line_buf
  import laplace_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  pixel_t        wr_data,
  output pixel_t        rd_data
);

  pixel_t mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/laplace_window_gen.sv
// laplace_window_gen
// Streaming 3x3-cross window generator feeding the Laplace adder tree.
// Takes a raster-order pixel stream and, for every interior pixel, emits the
// centre and its N/S/E/W neighbours as one registered beat.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_pixel/in_sof/in_valid   input pixel stream, in_sof marks pixel (0,0)
//   in_ready                   input can be accepted this cycle
//   win_c/n/s/e/w              window output fields
//   out_first/out_last         first / last window of the frame
//   out_valid/out_ready        output handshake
module laplace_window_gen
  import laplace_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic   clk,
  input  logic   rst_n,
  input  pixel_t in_pixel,
  input  logic   in_sof,
  input  logic   in_valid,
  output logic   in_ready,
  output pixel_t win_c,
  output pixel_t win_n,
  output pixel_t win_s,
  output pixel_t win_e,
  output pixel_t win_w,
  output logic   out_first,
  output logic   out_last,
  output logic   out_valid,
  input  logic   out_ready
);

  localparam int COL_W = cnt_width(IMG_WIDTH);
  localparam int ROW_W = cnt_width(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_PEN  = COL_W'(IMG_WIDTH - 2);
  localparam logic [ROW_W-1:0] ROW_PEN  = ROW_W'(IMG_HEIGHT - 2);

  generate
    if (IMG_WIDTH < 3 || IMG_WIDTH > 4096 || IMG_HEIGHT < 3 || IMG_HEIGHT > 4096) begin : g_bad_size
      $error("laplace_window_gen: image size out of range 3..4096");
    end
  endgenerate

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] pos_col;
  logic [ROW_W-1:0] pos_row;

  logic   accept;
  logic   win_gen;
  pixel_t lb1_rd;
  pixel_t lb2_rd;

  // Index 0 holds column col-1, index 1 holds column col-2 of each row tap.
  pixel_t [1:0] tap_top_q, tap_top_d;
  pixel_t [1:0] tap_mid_q, tap_mid_d;
  pixel_t [1:0] tap_bot_q, tap_bot_d;

  window_t win_q, win_d;
  logic    first_q, first_d;
  logic    last_q, last_d;
  logic    out_valid_q, out_valid_d;

  // The output register is free when empty or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // in_sof overrides the counters so a resynchronised frame starts cleanly.
  always_comb begin
    pos_col = col_q;
    pos_row = row_q;
    if (in_sof) begin
      pos_col = '0;
      pos_row = '0;
    end
  end

  // A pixel at column >= 2 of row >= 2 is the south-east corner of the cross
  // centred one row up and one column left; only then is the window complete.
  assign win_gen = accept && (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));

  laplace_line_buf #(
    .DEPTH (IMG_WIDTH),
    .AW    (COL_W)
  ) u_lb1 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (pos_col),
    .wr_data (in_pixel),
    .rd_data (lb1_rd)
  );

  // LB2 receives what LB1 held at this column, ageing the row by one.
  laplace_line_buf #(
    .DEPTH (IMG_WIDTH),
    .AW    (COL_W)
  ) u_lb2 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (pos_col),
    .wr_data (lb1_rd),
    .rd_data (lb2_rd)
  );

  // Raster position tracking; the frame wraps after the last pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + ROW_W'(1);
      end else begin
        col_d = pos_col + COL_W'(1);
        row_d = pos_row;
      end
    end
  end

  // Column delay lines per row tap. They are not cleared at row wrap: the
  // first two columns of a row never complete a window, which flushes them.
  always_comb begin
    tap_top_d = tap_top_q;
    tap_mid_d = tap_mid_q;
    tap_bot_d = tap_bot_q;
    if (accept) begin
      tap_top_d = {tap_top_q[0], lb2_rd};
      tap_mid_d = {tap_mid_q[0], lb1_rd};
      tap_bot_d = {tap_bot_q[0], in_pixel};
    end
  end

  // Output register: load a new window when one completes, otherwise hold
  // the fields and drop valid once the downstream has taken the beat.
  always_comb begin
    win_d       = win_q;
    first_d     = first_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (win_gen) begin
      win_d.c     = tap_mid_q[0];
      win_d.n     = tap_top_q[0];
      win_d.s     = tap_bot_q[0];
      win_d.w     = tap_mid_q[1];
      win_d.e     = lb1_rd;
      first_d     = (pos_row == ROW_W'(2)) && (pos_col == COL_W'(2));
      last_d      = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      tap_top_q   <= '0;
      tap_mid_q   <= '0;
      tap_bot_q   <= '0;
      win_q       <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      tap_top_q   <= tap_top_d;
      tap_mid_q   <= tap_mid_d;
      tap_bot_q   <= tap_bot_d;
      win_q       <= win_d;
      first_q     <= first_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign win_c     = win_q.c;
  assign win_n     = win_q.n;
  assign win_s     = win_q.s;
  assign win_e     = win_q.e;
  assign win_w     = win_q.w;
  assign out_first = first_q;
  assign out_last  = last_q;
  assign out_valid = out_valid_q;

  // Unused-parameter guard: the penultimate indices document the last centre.
  logic unused_pen;
  assign unused_pen = ^{COL_PEN, ROW_PEN};

endmodule

// File: tb/tb_laplace_window_gen.sv
// tb_laplace_window_gen
// Directed bench for laplace_window_gen on a 5x4 image where pixel (r,c)
// carries base + 10*r + c, so every expected window field can be worked out
// by hand from its coordinates.
module tb_laplace_window_gen;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_pixel;
  logic       in_sof;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] win_c, win_n, win_s, win_e, win_w;
  logic       out_first, out_last, out_valid, out_ready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [41:0] got_q[$];

  laplace_window_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pixel  (in_pixel),
    .in_sof    (in_sof),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .win_c     (win_c),
    .win_n     (win_n),
    .win_s     (win_s),
    .win_e     (win_e),
    .win_w     (win_w),
    .out_first (out_first),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every beat that will transfer on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back({out_first, out_last, win_c, win_n, win_s, win_e, win_w});
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [41:0] packWin(input logic f, input logic l,
                                          input int c, input int n, input int s,
                                          input int e, input int w);
    logic [7:0] c8, n8, s8, e8, w8;
    c8 = 8'(c); n8 = 8'(n); s8 = 8'(s); e8 = 8'(e); w8 = 8'(w);
    return {f, l, c8, n8, s8, e8, w8};
  endfunction

  function automatic int pix(input int base, input int r, input int c);
    return base + 10 * r + c;
  endfunction

  function automatic logic [41:0] expWin(input int base, input int r, input int c);
    return packWin(r == 1 && c == 1, r == H - 2 && c == W - 2,
                   pix(base, r, c), pix(base, r - 1, c), pix(base, r + 1, c),
                   pix(base, r, c + 1), pix(base, r, c - 1));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one beat, optionally preceded by random idle cycles that also wave
  // in_sof around with in_valid low; those must be ignored by the block.
  task automatic sendBeat(input logic [7:0] px, input logic sof, input int gap_pct);
    logic acc;
    int   n;
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      in_sof   = 1'b1;
      in_pixel = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = px;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) checkOutput("in_ready timeout", {63'd0, acc}, 64'd1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic applyStimulus(input int base, input int gap_pct, input logic first_sof);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        sendBeat(8'(pix(base, r, c)), first_sof && r == 0 && c == 0, gap_pct);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkFrame(input string tag, input int base, input int start);
    int k;
    k = start;
    for (int r = 1; r <= H - 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        if (k < got_q.size()) checkOutput(tag, {22'd0, got_q[k]}, {22'd0, expWin(base, r, c)});
        k++;
      end
    end
  endtask

  initial begin
    int t0;
    int nf;
    int nl;
    logic [41:0] held;
    logic found;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pixel  = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("reset window", {22'd0, out_first, out_last, win_c, win_n, win_s, win_e, win_w}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Scenario 1: clean frame at full rate.
    $display("[TB] scenario 1: single frame, no gaps");
    got_q.delete();
    t0 = cyc;
    applyStimulus(0, 0, 1'b1);
    checkOutput("s1 input cycles", 64'(cyc - t0), 64'(W * H));
    drain();
    checkOutput("s1 count", 64'(got_q.size()), 64'(6));
    if (got_q.size() == 6) begin
      checkOutput("s1 first", {22'd0, got_q[0]}, {22'd0, packWin(1, 0, 11, 1, 21, 12, 10)});
      checkOutput("s1 last", {22'd0, got_q[5]}, {22'd0, packWin(0, 1, 23, 13, 33, 24, 22)});
    end
    checkFrame("s1 window", 0, 0);

    // Scenario 2: downstream stalls three cycles while window C=12 is held.
    $display("[TB] scenario 2: output stall");
    got_q.delete();
    fork
      applyStimulus(0, 0, 1'b0);
      begin
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
          @(posedge clk);
          #1;
          if (out_valid && win_c == 8'd12) found = 1'b1;
        end
        checkOutput("s2 window 2 seen", {63'd0, found}, 64'd1);
        if (found) begin
          out_ready = 1'b0;
          held = packWin(0, 0, 12, 2, 22, 13, 11);
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("s2 stall in_ready", {63'd0, in_ready}, 64'd0);
            checkOutput("s2 stall valid", {63'd0, out_valid}, 64'd1);
            checkOutput("s2 stall hold",
                        {22'd0, out_first, out_last, win_c, win_n, win_s, win_e, win_w},
                        {22'd0, held});
            @(posedge clk);
            #1;
          end
          out_ready = 1'b1;
        end
      end
    join
    drain();
    checkOutput("s2 count", 64'(got_q.size()), 64'(6));
    checkFrame("s2 window", 0, 0);

    // Scenario 3: random input gaps, same expected sequence.
    $display("[TB] scenario 3: random input gaps");
    got_q.delete();
    applyStimulus(0, 50, 1'b0);
    drain();
    checkOutput("s3 count", 64'(got_q.size()), 64'(6));
    checkFrame("s3 window", 0, 0);

    // Scenario 4: partial frame abandoned by in_sof on what would be (2,3).
    $display("[TB] scenario 4: mid-frame in_sof");
    got_q.delete();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < ((r == 2) ? 3 : W); c++) begin
        sendBeat(8'(pix(200, r, c)), r == 0 && c == 0, 0);
      end
    end
    drain();
    checkOutput("s4 partial count", 64'(got_q.size()), 64'(1));
    if (got_q.size() == 1) checkOutput("s4 partial win", {22'd0, got_q[0]}, {22'd0, expWin(200, 1, 1)});
    got_q.delete();
    applyStimulus(0, 0, 1'b1);
    drain();
    checkOutput("s4 count", 64'(got_q.size()), 64'(6));
    if (got_q.size() > 0) checkOutput("s4 first C", 64'(got_q[0][39:32]), 64'(11));
    checkFrame("s4 window", 0, 0);

    // Scenario 5: reset while a window is waiting on the output.
    $display("[TB] scenario 5: reset mid-frame");
    out_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < ((r == 2) ? 3 : W); c++) begin
        sendBeat(8'(pix(0, r, c)), r == 0 && c == 0, 0);
      end
    end
    @(negedge clk);
    checkOutput("s5 pending valid", {63'd0, out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s5 async valid", {63'd0, out_valid}, 64'd0);
    checkOutput("s5 async window", {22'd0, out_first, out_last, win_c, win_n, win_s, win_e, win_w}, 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 1'b0);
    drain();
    checkOutput("s5 count", 64'(got_q.size()), 64'(6));
    checkFrame("s5 window", 0, 0);

    // Scenario 6: two frames back to back; the second relies on counter wrap.
    $display("[TB] scenario 6: back-to-back frames");
    got_q.delete();
    applyStimulus(0, 0, 1'b1);
    applyStimulus(100, 0, 1'b0);
    drain();
    checkOutput("s6 count", 64'(got_q.size()), 64'(12));
    checkFrame("s6 frame A", 0, 0);
    checkFrame("s6 frame B", 100, 6);
    nf = 0;
    nl = 0;
    foreach (got_q[i]) begin
      if (got_q[i][41]) nf++;
      if (got_q[i][40]) nl++;
    end
    checkOutput("s6 first flags", 64'(nf), 64'(2));
    checkOutput("s6 last flags", 64'(nl), 64'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
